weight_mem_loader: RTL and testbench

//  Write-side companion of a per-neuron weight memory. Accepts a valid/ready stream of weight words,

---
 rtl/weight_mem_loader.sv | 119 +++++++++++
 tb/tb_weight_mem_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/weight_mem_loader.sv
// ============================================================================
// Module      : weight_mem_loader
// Description : Filters a valid/ready weight stream by (layer, neuron) and
//               writes the matching words into one neuron's weight RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_mem_loader #(
    parameter int layerNo      = 1,
    parameter int neuronNo     = 4,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16,
    parameter int numWeight    = 784
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           config_layer_num,
    input  logic [31:0]           config_neuron_num,
    input  logic                  load_clear,
    input  logic                  weight_valid,
    input  logic [dataWidth-1:0]  weight_in,
    output logic                  weight_ready,
    output logic                  wen,
    output logic [addressWidth:0] waddr,
    output logic [dataWidth-1:0]  win,
    output logic                  load_done
);

    localparam int                CW        = addressWidth + 1;
    localparam logic [CW-1:0]     c_last    = CW'(numWeight - 1);
    localparam logic [31:0]       c_layer   = 32'(layerNo);
    localparam logic [31:0]       c_neuron  = 32'(neuronNo);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;
    logic            w_xfer;
    logic            w_match;
    logic            w_last;
    logic            w_write;

    assign w_xfer  = weight_valid & weight_ready;
    assign w_match = (config_layer_num == c_layer) && (config_neuron_num == c_neuron);
    assign w_last  = (r_count == c_last);

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_write     = 1'b0;
        if (load_clear) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE, S_LOAD: begin
                    // Non-matching words are still consumed, just never written
                    if (w_xfer && w_match) begin
                        w_write = 1'b1;
                        if (w_last) begin
                            w_state_nxt = S_DONE;
                            w_count_nxt = '0;
                        end else begin
                            w_state_nxt = S_LOAD;
                            w_count_nxt = r_count + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // RAM-side outputs are registered; waddr/win hold between writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_ready <= 1'b0;
            wen          <= 1'b0;
            waddr        <= '0;
            win          <= '0;
            load_done    <= 1'b0;
        end else begin
            weight_ready <= (w_state_nxt != S_DONE);
            wen          <= w_write;
            load_done    <= (w_state_nxt == S_DONE);
            if (w_write) begin
                waddr <= r_count;
                win   <= weight_in;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_weight_mem_loader.sv
// ============================================================================
// Module      : tb_weight_mem_loader
// Description : Scoreboard bench for weight_mem_loader (numWeight=4 and =1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_weight_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] config_layer_num = '0;
    logic [31:0] config_neuron_num = '0;
    logic        load_clear = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [15:0] w0 = '0, w1 = '0;
    logic        rdy0, rdy1, wen0, wen1, done0, done1;
    logic [10:0] addr0, addr1;
    logic [15:0] win0, win1;

    always #5 clk = ~clk;

    weight_mem_loader #(.layerNo(1), .neuronNo(4), .addressWidth(10), .dataWidth(16), .numWeight(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .config_layer_num(config_layer_num),
        .config_neuron_num(config_neuron_num), .load_clear(load_clear),
        .weight_valid(v0), .weight_in(w0), .weight_ready(rdy0),
        .wen(wen0), .waddr(addr0), .win(win0), .load_done(done0));

    weight_mem_loader #(.layerNo(1), .neuronNo(4), .addressWidth(10), .dataWidth(16), .numWeight(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .config_layer_num(config_layer_num),
        .config_neuron_num(config_neuron_num), .load_clear(load_clear),
        .weight_valid(v1), .weight_in(w1), .weight_ready(rdy1),
        .wen(wen1), .waddr(addr1), .win(win1), .load_done(done1));

    typedef struct {
        int          cyc;
        logic [10:0] addr;
        logic [15:0] data;
        bit          done;
    } wr_t;

    wr_t         q0[$];
    wr_t         q1[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          nw[2] = '{4, 1};
    int          m_cnt[2] = '{0, 0};
    bit          m_done[2] = '{0, 0};
    bit          m_rdy[2] = '{0, 0};
    bit          s_have[2] = '{0, 0};
    logic [15:0] s_word[2] = '{16'h0011, 16'h0000};
    logic [15:0] seq_word[2] = '{16'h0011, 16'hABCD};

    // Reference model: words written so far, and whether this is the done cycle
    task automatic step(input int k, input bit clr, input bit v, input bit match,
                        input logic [15:0] w, output bit consumed);
        wr_t it;
        consumed = v && m_rdy[k];
        if (clr) begin
            m_cnt[k]  = 0;
            m_done[k] = 0;
        end else if (m_done[k]) begin
            m_cnt[k]  = 0;
            m_done[k] = 0;
        end else if (consumed && match) begin
            it.cyc  = cyc + 1;
            it.addr = 11'(m_cnt[k]);
            it.data = w;
            it.done = (m_cnt[k] == nw[k] - 1);
            if (k == 0) q0.push_back(it);
            else        q1.push_back(it);
            if (it.done) begin
                m_cnt[k]  = 0;
                m_done[k] = 1;
            end else begin
                m_cnt[k]++;
            end
        end
        m_rdy[k] = !m_done[k];
    endtask

    task automatic drive(input bit clr, input bit want_match, input bit en0, input bit en1, input bit rnd);
        bit match;
        bit used;
        @(negedge clk);
        load_clear = clr;
        if (want_match) begin
            config_layer_num  = 32'd1;
            config_neuron_num = 32'd4;
        end else begin
            config_layer_num  = ($urandom_range(1) == 0) ? 32'd1 : 32'd2;
            config_neuron_num = (config_layer_num == 32'd1) ? 32'd5 : 32'($urandom_range(7));
        end
        match = (config_layer_num == 32'd1) && (config_neuron_num == 32'd4);
        for (int k = 0; k < 2; k++) begin
            if (!s_have[k] && ((k == 0) ? en0 : en1)) begin
                s_have[k] = 1;
                if (rnd) s_word[k] = 16'($urandom);
                else begin
                    s_word[k]   = seq_word[k];
                    seq_word[k] = seq_word[k] + 16'd1;
                end
            end
        end
        v0 = s_have[0]; w0 = s_word[0];
        v1 = s_have[1]; w1 = s_word[1];
        for (int k = 0; k < 2; k++) begin
            step(k, clr, s_have[k], match, s_word[k], used);
            if (used) s_have[k] = 0;
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk(input int k, input logic rdy, input logic wen, input logic [10:0] a,
                       input logic [15:0] d, input logic done);
        wr_t it;
        bit  have = 0;
        n_cmp++;
        if (rdy !== m_rdy[k]) begin
            n_bad++;
            $display("FAIL ready%0d cyc %0d: got %b want %b", k, cyc, rdy, m_rdy[k]);
        end
        if (k == 0 && q0.size() > 0 && q0[0].cyc <= cyc) begin it = q0.pop_front(); have = 1; end
        if (k == 1 && q1.size() > 0 && q1[0].cyc <= cyc) begin it = q1.pop_front(); have = 1; end
        if (have || wen !== 1'b0 || done !== 1'b0) begin
            n_cmp++;
            if (!have) begin
                n_bad++;
                $display("FAIL write%0d cyc %0d: got wen=%b done=%b addr=%0d want no write", k, cyc, wen, done, a);
            end else if (it.cyc != cyc || wen !== 1'b1) begin
                n_bad++;
                $display("FAIL write%0d cyc %0d: got wen=%b want write addr=%0d due cyc %0d", k, cyc, wen, it.addr, it.cyc);
            end else if (a !== it.addr || d !== it.data || done !== it.done) begin
                n_bad++;
                $display("FAIL write%0d cyc %0d: got addr=%0d data=%h done=%b want addr=%0d data=%h done=%b",
                         k, cyc, a, d, done, it.addr, it.data, it.done);
            end
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        chk(0, rdy0, wen0, addr0, win0, done0);
        chk(1, rdy1, wen1, addr1, win1, done1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        cmp("reset_wen0", {31'd0, wen0}, 32'd0);
        cmp("reset_waddr0", {21'd0, addr0}, 32'd0);
        cmp("reset_win0", {16'd0, win0}, 32'd0);

        // 4 back-to-back matching words 0x11..0x14
        for (int i = 0; i < 4; i++) drive(0, 1, 1, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);

        // non-matching words interleaved with matching ones
        for (int i = 0; i < 6; i++) drive(0, (i % 2 == 0) || (i > 3), 1, 0, 1);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);

        // valid held through DONE
        for (int i = 0; i < 10; i++) drive(0, 1, 1, 0, 1);
        while (s_have[0]) drive(0, 1, 0, 0, 1);
        drive(0, 0, 0, 0, 1);

        // clear after two writes, concurrent with a matching word
        drive(1, 1, 0, 0, 1);
        drive(0, 1, 1, 0, 1);
        drive(0, 1, 1, 0, 1);
        drive(1, 1, 1, 0, 1);
        drive(0, 1, 1, 0, 1);
        drive(0, 1, 0, 0, 1);

        // asynchronous reset mid-load
        drive(0, 1, 1, 0, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp("async_wen0", {31'd0, wen0}, 32'd0);
        cmp("async_ready0", {31'd0, rdy0}, 32'd0);
        cmp("async_done0", {31'd0, done0}, 32'd0);
        cmp("async_waddr0", {21'd0, addr0}, 32'd0);
        cmp("async_ready1", {31'd0, rdy1}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_done[k] = 0; m_rdy[k] = 0; s_have[k] = 0;
        end
        v0 = 1'b0; v1 = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) drive(0, 1, 1, 0, 1);
        drive(1, 0, 0, 0, 1);

        // numWeight=1: single word 0xABCD
        drive(0, 1, 0, 1, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);

        for (int i = 0; i < 400; i++)
            drive($urandom_range(99) < 3, $urandom_range(99) < 70,
                  1'($urandom_range(1)), 1'($urandom_range(1)), 1);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1);
        @(posedge clk);
        #2;
        cmp("queues_drained", 32'(q0.size() + q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
